// File: rtl/hash_drbg_sequencer.sv
// rtl/hash_drbg_sequencer.sv - Hash-DRBG instantiate/generate/reseed sequencer driving an external hash core
module hash_drbg_sequencer #(
  parameter int STATE_W                  = 256,
  parameter int OUT_W                    = 256,
  parameter int BITS_GENERATOR_MAX_CYCLE = 3,
  parameter int SEED_GENERATOR_MAX_CYCLE = 3,
  parameter int CNT_W                    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_master_mode,
  input  logic               catch_up_mode,
  input  logic [CNT_W-1:0]   catch_up_target,
  input  logic               init,
  input  logic               next_bits,
  input  logic               next_seed,
  input  logic [STATE_W-1:0] entropy,
  output logic               hash_start,
  output logic [STATE_W+7:0] hash_msg,
  input  logic               hash_done,
  input  logic [STATE_W-1:0] hash_digest,
  output logic               init_ready,
  output logic               next_bits_ready,
  output logic [OUT_W-1:0]   random_bits,
  output logic [CNT_W-1:0]   reseed_counter,
  output logic [CNT_W-1:0]   gen_total,
  output logic               exhausted
);

  typedef enum logic [2:0] {
    IDLE, INIT_H, READY, GEN_H, GEN_OUT, RESEED_H, WAIT_SEED, EXH
  } state_t;

  localparam logic [CNT_W-1:0] BITS_MAX = CNT_W'(BITS_GENERATOR_MAX_CYCLE);
  localparam logic [CNT_W-1:0] SEED_MAX = CNT_W'(SEED_GENERATOR_MAX_CYCLE);

  state_t             state, state_n;
  logic [STATE_W-1:0] v, v_n, msg_data;
  logic [7:0]         msg_dom;
  logic [CNT_W-1:0]   seed_gens;
  logic               issue, catchup, catchup_n, reseed, catch_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  assign catch_req       = catch_up_mode && (gen_total < catch_up_target);
  assign init_ready      = (state == READY);
  assign next_bits_ready = (state == GEN_OUT);
  assign exhausted       = (state == EXH);

  always_comb begin
    state_n   = state;
    v_n       = v;
    issue     = 1'b0;
    msg_dom   = 8'h00;
    msg_data  = v;
    catchup_n = catchup;
    reseed    = 1'b0;
    case (state)
      IDLE, EXH: begin
        if (init) begin
          state_n  = INIT_H;
          issue    = 1'b1;
          msg_data = entropy;
        end
      end
      INIT_H: begin
        if (hash_done) begin
          v_n     = hash_digest;
          state_n = READY;
        end
      end
      READY: begin
        if (init) begin
          state_n  = INIT_H;
          issue    = 1'b1;
          msg_data = entropy;
        end else if (next_bits || catch_req) begin
          // a fresh request after the last permitted reseed has nothing left to draw on
          if (reseed_counter >= SEED_MAX) begin
            state_n = EXH;
          end else begin
            state_n   = GEN_H;
            issue     = 1'b1;
            msg_dom   = 8'h03;
            catchup_n = !next_bits;
          end
        end
      end
      GEN_H: begin
        if (hash_done) begin
          v_n = v + hash_digest;
          if (!catchup)                               state_n = GEN_OUT;
          else if (sat_inc(seed_gens) >= BITS_MAX)    reseed  = 1'b1;
          else                                        state_n = READY;
        end
      end
      GEN_OUT: begin
        if (!next_bits) begin
          if (seed_gens >= BITS_MAX) reseed  = 1'b1;
          else                       state_n = READY;
        end
      end
      WAIT_SEED: begin
        if (next_seed) begin
          state_n  = RESEED_H;
          issue    = 1'b1;
          msg_dom  = 8'h01;
          msg_data = entropy;
        end
      end
      RESEED_H: begin
        if (hash_done) begin
          v_n     = hash_digest;
          state_n = READY;
        end
      end
      default: state_n = IDLE;
    endcase

    // reseed data is the post-generate V, which may be updated this very cycle
    if (reseed) begin
      if (reseed_counter >= SEED_MAX) begin
        state_n = EXH;
      end else if (is_master_mode) begin
        state_n  = RESEED_H;
        issue    = 1'b1;
        msg_dom  = 8'h01;
        msg_data = v_n;
      end else begin
        state_n = WAIT_SEED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      v              <= '0;
      catchup        <= 1'b0;
      hash_start     <= 1'b0;
      hash_msg       <= '0;
      random_bits    <= '0;
      reseed_counter <= '0;
      gen_total      <= '0;
      seed_gens      <= '0;
    end else begin
      state      <= state_n;
      v          <= v_n;
      catchup    <= catchup_n;
      hash_start <= issue;
      if (issue) hash_msg <= {msg_dom, msg_data};
      if (hash_done) begin
        case (state)
          INIT_H: begin
            reseed_counter <= '0;
            gen_total      <= '0;
            seed_gens      <= '0;
          end
          GEN_H: begin
            random_bits <= hash_digest[OUT_W-1:0];
            gen_total   <= sat_inc(gen_total);
            seed_gens   <= sat_inc(seed_gens);
          end
          RESEED_H: begin
            reseed_counter <= sat_inc(reseed_counter);
            seed_gens      <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hash_drbg_sequencer.sv
// tb/tb_hash_drbg_sequencer.sv - directed bench for hash_drbg_sequencer with a data+1 stub hash
module tb_hash_drbg_sequencer;
  logic         clk = 1'b0;
  logic         reset, is_master_mode, catch_up_mode, init, next_bits, next_seed;
  logic [63:0]  catch_up_target;
  logic [255:0] entropy;
  logic         hash_start, hash_done;
  logic [263:0] hash_msg;
  logic [255:0] hash_digest;
  logic         init_ready, next_bits_ready, exhausted;
  logic [255:0] random_bits;
  logic [63:0]  reseed_counter, gen_total;

  int cmp_count  = 0;
  int fail_count = 0;

  logic         stub_busy = 1'b0;
  logic [2:0]   stub_dly  = '0;
  logic [255:0] stub_data = '0;

  always #5 clk = ~clk;

  hash_drbg_sequencer dut (
    .clk(clk), .reset(reset), .is_master_mode(is_master_mode),
    .catch_up_mode(catch_up_mode), .catch_up_target(catch_up_target),
    .init(init), .next_bits(next_bits), .next_seed(next_seed), .entropy(entropy),
    .hash_start(hash_start), .hash_msg(hash_msg), .hash_done(hash_done),
    .hash_digest(hash_digest), .init_ready(init_ready),
    .next_bits_ready(next_bits_ready), .random_bits(random_bits),
    .reseed_counter(reseed_counter), .gen_total(gen_total), .exhausted(exhausted)
  );

  // stub hash: digest = data + 1, hash_done four cycles after hash_start
  initial begin
    hash_done   = 1'b0;
    hash_digest = '0;
  end
  always @(posedge clk) begin
    hash_done <= 1'b0;
    if (hash_start) begin
      stub_busy <= 1'b1;
      stub_dly  <= 3'd3;
      stub_data <= hash_msg[255:0];
    end else if (stub_busy) begin
      if (stub_dly == 0) begin
        hash_done   <= 1'b1;
        hash_digest <= stub_data + 1;
        stub_busy   <= 1'b0;
      end else begin
        stub_dly <= stub_dly - 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; init = 0; next_bits = 0; next_seed = 0;
    catch_up_mode = 0; catch_up_target = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_init(input logic [255:0] ent, output bit ok);
    @(negedge clk);
    entropy = ent; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_ready(ok);
  endtask

  task automatic do_gen(output logic [255:0] rb, output bit ok);
    ok = 1'b0; rb = '0;
    @(negedge clk);
    next_bits = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (next_bits_ready) begin ok = 1'b1; break; end
    end
    rb = random_bits;
    next_bits = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    cmp_count++;
    if ({hash_start, init_ready, next_bits_ready, exhausted} !== 4'b0) begin
      fail_count++;
      $display("FAIL reset_flags got %b want 0000", {hash_start, init_ready, next_bits_ready, exhausted});
    end
    cmp_count++;
    if (random_bits !== '0 || reseed_counter !== '0 || gen_total !== '0 || hash_msg !== '0) begin
      fail_count++;
      $display("FAIL reset_values rb=%0h rc=%0d gt=%0d msg=%0h want all 0", random_bits, reseed_counter, gen_total, hash_msg);
    end
  endtask

  task automatic test_master_generate();
    logic [255:0] rb;
    logic [255:0] exp_rb [4] = '{256'd2, 256'd4, 256'd8, 256'd17};
    bit ok;
    is_master_mode = 1'b1;
    do_init(256'd0, ok);
    cmp_count++;
    if (!ok || gen_total !== 0) begin
      fail_count++;
      $display("FAIL master_init ready=%0b gt=%0d want ready=1 gt=0", ok, gen_total);
    end
    for (int i = 0; i < 3; i++) begin
      do_gen(rb, ok);
      cmp_count++;
      if (!ok || rb !== exp_rb[i]) begin
        fail_count++;
        $display("FAIL master_gen%0d got %0d (ok=%0b) want %0d", i + 1, rb, ok, exp_rb[i]);
      end
    end
    wait_ready(ok);
    cmp_count++;
    if (!ok || reseed_counter !== 1 || init_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL master_reseed rc=%0d ready=%0b want rc=1 ready=1", reseed_counter, init_ready);
    end
    do_gen(rb, ok);
    cmp_count++;
    if (!ok || rb !== exp_rb[3] || gen_total !== 4) begin
      fail_count++;
      $display("FAIL master_gen4 got %0d gt=%0d want 17 gt=4", rb, gen_total);
    end
  endtask

  task automatic test_exhaust();
    logic [255:0] rb;
    logic [255:0] exp_rb [5] = '{256'd34, 256'd68, 256'd137, 256'd274, 256'd548};
    bit ok;
    for (int i = 0; i < 5; i++) begin
      do_gen(rb, ok);
      cmp_count++;
      if (!ok || rb !== exp_rb[i]) begin
        fail_count++;
        $display("FAIL exh_gen%0d got %0d want %0d", i + 5, rb, exp_rb[i]);
      end
    end
    wait_ready(ok);
    cmp_count++;
    if (!ok || reseed_counter !== 3 || gen_total !== 9) begin
      fail_count++;
      $display("FAIL exh_pre rc=%0d gt=%0d want rc=3 gt=9", reseed_counter, gen_total);
    end
    @(negedge clk);
    next_bits = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exhausted) begin ok = 1'b1; break; end
    end
    cmp_count++;
    if (!ok || init_ready !== 1'b0 || next_bits_ready !== 1'b0 || gen_total !== 9) begin
      fail_count++;
      $display("FAIL exh_state exh=%0b ready=%0b nbr=%0b gt=%0d want 1 0 0 9", exhausted, init_ready, next_bits_ready, gen_total);
    end
    next_bits = 1'b0;
    do_init(256'd0, ok);
    cmp_count++;
    if (!ok || exhausted !== 1'b0 || reseed_counter !== 0 || gen_total !== 0) begin
      fail_count++;
      $display("FAIL exh_reinit exh=%0b rc=%0d gt=%0d want 0 0 0", exhausted, reseed_counter, gen_total);
    end
    do_gen(rb, ok);
    cmp_count++;
    if (!ok || rb !== 256'd2) begin
      fail_count++;
      $display("FAIL exh_regen got %0d want 2", rb);
    end
  endtask

  task automatic test_slave();
    logic [255:0] rb;
    bit ok;
    do_reset();
    is_master_mode = 1'b0;
    do_init(256'd0, ok);
    for (int i = 0; i < 3; i++) do_gen(rb, ok);
    repeat (20) @(negedge clk);
    cmp_count++;
    if (init_ready !== 1'b0 || reseed_counter !== 0 || rb !== 256'd8) begin
      fail_count++;
      $display("FAIL slave_wait ready=%0b rc=%0d rb=%0d want 0 0 8", init_ready, reseed_counter, rb);
    end
    entropy   = 256'h10;
    next_seed = 1'b1;
    @(negedge clk);
    next_seed = 1'b0;
    wait_ready(ok);
    cmp_count++;
    if (!ok || reseed_counter !== 1) begin
      fail_count++;
      $display("FAIL slave_reseed rc=%0d want 1", reseed_counter);
    end
    do_gen(rb, ok);
    cmp_count++;
    if (!ok || rb !== 256'h12) begin
      fail_count++;
      $display("FAIL slave_gen got %0h want 12", rb);
    end
  endtask

  task automatic test_catch_up();
    logic [255:0] rb;
    bit ok, nbr_seen;
    do_reset();
    is_master_mode  = 1'b1;
    catch_up_mode   = 1'b1;
    catch_up_target = 64'd5;
    nbr_seen = 1'b0;
    @(negedge clk);
    entropy = '0; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (next_bits_ready) nbr_seen = 1'b1;
      if (init_ready && gen_total == 5) begin ok = 1'b1; break; end
    end
    cmp_count++;
    if (!ok || reseed_counter !== 1 || nbr_seen || random_bits !== 256'd34) begin
      fail_count++;
      $display("FAIL catchup gt=%0d rc=%0d nbr_seen=%0b rb=%0d want 5 1 0 34", gen_total, reseed_counter, nbr_seen, random_bits);
    end
    repeat (20) @(negedge clk);
    cmp_count++;
    if (gen_total !== 5 || init_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL catchup_noop gt=%0d ready=%0b want 5 1", gen_total, init_ready);
    end
    do_gen(rb, ok);
    cmp_count++;
    if (!ok || rb !== 256'd68 || gen_total !== 6) begin
      fail_count++;
      $display("FAIL catchup_next got %0d gt=%0d want 68 6", rb, gen_total);
    end
    catch_up_mode = 1'b0;
  endtask

  task automatic test_reset_mid_hash();
    logic [255:0] rb;
    bit ok, restart;
    do_reset();
    is_master_mode = 1'b1;
    do_init(256'd0, ok);
    do_gen(rb, ok);
    @(negedge clk);
    next_bits = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hash_start) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    reset = 1'b1; next_bits = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cmp_count++;
    if (!ok || {hash_start, init_ready, next_bits_ready, exhausted} !== 4'b0 ||
        random_bits !== '0 || gen_total !== '0 || reseed_counter !== '0 || hash_msg !== '0) begin
      fail_count++;
      $display("FAIL midhash_reset start_seen=%0b rb=%0d gt=%0d msg=%0h want all 0", ok, random_bits, gen_total, hash_msg);
    end
    restart = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (hash_start || init_ready || next_bits_ready) restart = 1'b1;
    end
    cmp_count++;
    if (restart || gen_total !== '0 || random_bits !== '0) begin
      fail_count++;
      $display("FAIL midhash_late_done activity=%0b gt=%0d rb=%0d want 0 0 0", restart, gen_total, random_bits);
    end
  endtask

  task automatic test_init_priority();
    logic [255:0] rb;
    bit ok;
    do_reset();
    is_master_mode = 1'b1;
    do_init(256'd0, ok);
    @(negedge clk);
    entropy = 256'h20; init = 1'b1; next_bits = 1'b1;
    @(negedge clk);
    init = 1'b0; next_bits = 1'b0;
    cmp_count++;
    if (hash_start !== 1'b1 || hash_msg !== {8'h00, 256'h20}) begin
      fail_count++;
      $display("FAIL prio_msg start=%0b msg=%0h want 1 %0h", hash_start, hash_msg, {8'h00, 256'h20});
    end
    wait_ready(ok);
    cmp_count++;
    if (!ok || gen_total !== 0) begin
      fail_count++;
      $display("FAIL prio_gt gt=%0d want 0", gen_total);
    end
    do_gen(rb, ok);
    cmp_count++;
    if (!ok || rb !== 256'h22) begin
      fail_count++;
      $display("FAIL prio_gen got %0h want 22", rb);
    end
  endtask

  initial begin
    reset = 1'b1; is_master_mode = 1'b1; catch_up_mode = 1'b0; catch_up_target = '0;
    init = 1'b0; next_bits = 1'b0; next_seed = 1'b0; entropy = '0;
    test_reset();
    test_master_generate();
    test_exhaust();
    test_slave();
    test_catch_up();
    test_reset_mid_hash();
    test_init_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end
endmodule
